cpu_sequencer: RTL

//  Parametrised control unit and instruction pointer for the multi-cycle CPU.

---
 rtl/cpu_sequencer_pkg.sv | 42 ++++
 rtl/cpu_sequencer_pointer.sv | 38 +++
 rtl/cpu_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
//   OP_*        4-bit decoded opcodes (OP_HALT added for the HALT state)
//   seq_state_t FSM state encoding, visible on cpu_sequencer.state
//   seq_strb_t  one-hot control strobes driven by the FSM
package cpu_sequencer_pkg;

  localparam int NIB_SIZE = 4;

  localparam logic [NIB_SIZE-1:0] OP_NOP    = 4'h0;
  localparam logic [NIB_SIZE-1:0] OP_LOADLO = 4'h1;
  localparam logic [NIB_SIZE-1:0] OP_LOADHI = 4'h2;
  localparam logic [NIB_SIZE-1:0] OP_STORE  = 4'h3;
  localparam logic [NIB_SIZE-1:0] OP_LOAD   = 4'h4;
  localparam logic [NIB_SIZE-1:0] OP_JMP    = 4'h5;
  localparam logic [NIB_SIZE-1:0] OP_BR     = 4'h6;
  localparam logic [NIB_SIZE-1:0] OP_IN     = 4'h7;
  localparam logic [NIB_SIZE-1:0] OP_OUT    = 4'h8;
  localparam logic [NIB_SIZE-1:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_FETCH    = 3'd1,
    S_REGLOAD  = 3'd2,
    S_ALU      = 3'd3,
    S_MEM      = 3'd4,
    S_REGSTORE = 3'd5,
    S_NEXT     = 3'd6,
    S_HALT     = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic rst;
    logic fetch;
    logic regload;
    logic aluop;
    logic memload;
    logic memstore;
    logic regstore;
    logic next;
  } seq_strb_t;

endpackage

// File: rtl/cpu_sequencer_pointer.sv
// seq_pointer: instruction pointer register with its adjustment mux.
//   clk, reset_n  clock / async active-low reset (loads RESET_VECTOR)
//   advance       apply the adjustment on this edge (the NEXT state)
//   opcode        selects jump / branch behaviour
//   bigval        signed offset, sign-extended to PTR_WIDTH
//   cond_val      branch condition, taken when non-zero
//   pointer       current instruction address
// Kept free of FSM knowledge so a pipelined core can reuse it directly.
module seq_pointer
  import cpu_sequencer_pkg::*;
#(
  parameter int                   WORD_SIZE    = 16,
  parameter int                   BYTE_SIZE    = 8,
  parameter int                   PTR_WIDTH    = 16,
  parameter logic [PTR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  advance,
  input  logic [NIB_SIZE-1:0]   opcode,
  input  logic [BYTE_SIZE-1:0]  bigval,
  input  logic [WORD_SIZE-1:0]  cond_val,
  output logic [PTR_WIDTH-1:0]  pointer
);

  logic                 take;
  logic [PTR_WIDTH-1:0] adj;

  assign take = (opcode == OP_JMP) || ((opcode == OP_BR) && (cond_val != '0));
  // Size cast of a signed value sign-extends; the add then wraps mod 2^PTR_WIDTH.
  assign adj  = take ? PTR_WIDTH'($signed(bigval)) : PTR_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     pointer <= RESET_VECTOR;
    else if (advance) pointer <= pointer + adj;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control FSM and instruction pointer for the multi-cycle CPU.
// Steps each instruction through FETCH/REGLOAD/ALU/MEM/REGSTORE/NEXT, with
// ready/valid stalls on fetch (instr_valid) and port I/O (port_req/port_ack),
// plus a HALT state that only reset_n leaves.
//   clk, reset_n       clock / async active-low reset
//   opcode, isaluop    decoded instruction class
//   bigval, cond_val   branch/jump offset and branch condition
//   instr_valid        fetch data valid
//   port_ack           port transfer complete (ignored outside MEM)
//   pointer            current instruction address
//   do_*               one-hot control strobes
//   port_req           port transfer pending (MEM)
//   halted             core in HALT
//   port_err           sticky port timeout flag
//   state              FSM state encoding
// Build option SEQ_PORT_TIMEOUT_EN: abandon a port wait after PORT_TIMEOUT
// un-acked MEM cycles and raise port_err. Undefined: MEM waits forever.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int                   WORD_SIZE    = 16,
  parameter int                   BYTE_SIZE    = 8,
  parameter int                   PTR_WIDTH    = 16,
  parameter logic [PTR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                   PORT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NIB_SIZE-1:0]   opcode,
  input  logic                  isaluop,
  input  logic [BYTE_SIZE-1:0]  bigval,
  input  logic [WORD_SIZE-1:0]  cond_val,
  input  logic                  instr_valid,
  input  logic                  port_ack,
  output logic [PTR_WIDTH-1:0]  pointer,
  output logic                  do_fetch,
  output logic                  do_regload,
  output logic                  do_aluop,
  output logic                  do_memload,
  output logic                  do_memstore,
  output logic                  do_regstore,
  output logic                  do_next,
  output logic                  do_reset,
  output logic                  port_req,
  output logic                  halted,
  output logic                  port_err,
  output logic [2:0]            state
);

  seq_state_t cur_st, nxt_st;
  seq_strb_t  strb;
  logic       mem_done;

  // A timeout below one cycle would leave MEM without ever sampling port_ack.
  if (PORT_TIMEOUT < 1) begin : g_bad_port_timeout
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_st <= S_RESET;
    else          cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st   = cur_st;
    strb     = '0;
    port_req = 1'b0;
    halted   = 1'b0;
    case (cur_st)
      S_RESET: begin
        strb.rst = 1'b1;
        nxt_st   = S_FETCH;
      end
      S_FETCH: begin
        strb.fetch = 1'b1;
        if (instr_valid) nxt_st = S_REGLOAD;
      end
      S_REGLOAD: begin
        strb.regload = 1'b1;
        if (opcode == OP_HALT)                          nxt_st = S_HALT;
        else if (isaluop)                               nxt_st = S_ALU;
        else if (opcode == OP_IN || opcode == OP_OUT)   nxt_st = S_MEM;
        else if (opcode == OP_LOADLO || opcode == OP_LOADHI) nxt_st = S_REGSTORE;
        else                                            nxt_st = S_NEXT;
      end
      S_ALU: begin
        strb.aluop = 1'b1;
        nxt_st     = S_REGSTORE;
      end
      S_MEM: begin
        port_req      = 1'b1;
        strb.memload  = (opcode == OP_IN);
        strb.memstore = (opcode == OP_OUT);
        if (mem_done) nxt_st = (opcode == OP_IN) ? S_REGSTORE : S_NEXT;
      end
      S_REGSTORE: begin
        strb.regstore = 1'b1;
        nxt_st        = S_NEXT;
      end
      S_NEXT: begin
        strb.next = 1'b1;
        nxt_st    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: nxt_st = S_RESET;
    endcase
  end

`ifdef SEQ_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(PORT_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // wait_cnt holds the number of un-acked MEM cycles already spent; an ack on
  // the expiring cycle wins, so it completes normally without an error.
  assign timeout  = (cur_st == S_MEM) && !port_ack &&
                    (wait_cnt == CNT_W'(PORT_TIMEOUT - 1));
  assign mem_done = port_ack || timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      port_err <= 1'b0;
    end else begin
      if (cur_st != S_MEM) wait_cnt <= '0;
      else if (!port_ack)  wait_cnt <= wait_cnt + 1'b1;
      if (timeout) port_err <= 1'b1;
    end
  end
`else
  assign mem_done = port_ack;
  assign port_err = 1'b0;
`endif

  seq_pointer #(
    .WORD_SIZE    (WORD_SIZE),
    .BYTE_SIZE    (BYTE_SIZE),
    .PTR_WIDTH    (PTR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (cur_st == S_NEXT),
    .opcode   (opcode),
    .bigval   (bigval),
    .cond_val (cond_val),
    .pointer  (pointer)
  );

  assign do_reset    = strb.rst;
  assign do_fetch    = strb.fetch;
  assign do_regload  = strb.regload;
  assign do_aluop    = strb.aluop;
  assign do_memload  = strb.memload;
  assign do_memstore = strb.memstore;
  assign do_regstore = strb.regstore;
  assign do_next     = strb.next;
  assign state       = cur_st;

endmodule
